// File: rtl/uart_host_pkg.sv
// Shared types and helpers for the UART host-side handshake initiator.
package uart_host_pkg;

  typedef enum logic [1:0] {HS_IDLE, HS_REQ, HS_REL, HS_GAP} hs_state_t;

  // Timeout counter width; a zero timeout still needs a 1-bit counter to exist.
  function automatic int cnt_width(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/uart_host_if_if.sv
// UART-side bus: four-phase TX load and RX unload handshakes plus status/enables.
interface uart_bus_if;
  logic       ld_tx_req;
  logic       ld_tx_ack;
  logic [7:0] tx_data;
  logic       tx_empty;
  logic       tx_enable;
  logic       uld_rx_req;
  logic       uld_rx_ack;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_enable;

  modport master (
    output ld_tx_req, tx_data, tx_enable, uld_rx_req, rx_enable,
    input  ld_tx_ack, tx_empty, uld_rx_ack, rx_data, rx_empty
  );

  modport slave (
    input  ld_tx_req, tx_data, tx_enable, uld_rx_req, rx_enable,
    output ld_tx_ack, tx_empty, uld_rx_ack, rx_data, rx_empty
  );
endinterface

// File: rtl/uart_host_if_hs_initiator.sv
// One four-phase initiator: IDLE -> REQ -> REL -> GAP with an ack timeout.
module hs_initiator
  import uart_host_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic ack,
  output logic req,
  output logic done,
  output logic abort,
  output logic busy
);

  localparam int CW = cnt_width(ACK_TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  hs_state_t     state;
  logic [CW-1:0] cnt;
  logic          expired;

  assign expired = (ACK_TIMEOUT > 0) && (cnt == LIMIT);
  // done marks the edge that first sees ack, so the caller can capture data then
  assign done    = (state == HS_REQ) && ack;
  assign abort   = expired && (((state == HS_REQ) && !ack) || ((state == HS_REL) && ack));
  assign busy    = (state != HS_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HS_IDLE;
      req   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        HS_IDLE: if (start) begin
          state <= HS_REQ;
          req   <= 1'b1;
          cnt   <= '0;
        end
        HS_REQ: if (ack) begin
          state <= HS_REL;
          req   <= 1'b0;
          cnt   <= '0;
        end else if (expired) begin
          state <= HS_IDLE;
          req   <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        HS_REL: if (!ack) begin
          state <= HS_GAP;
        end else if (expired) begin
          state <= HS_IDLE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        HS_GAP:  state <= HS_IDLE;
        default: state <= HS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_host_if.sv
// Host-side initiator: moves host TX bytes into the UART and drains UART RX bytes
// into a one-byte receive buffer with done/overrun/timeout status.
module uart_host_if
  import uart_host_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_tx_wr,
  input  logic [7:0]  host_tx_data,
  output logic        host_tx_rdy,
  input  logic        host_rx_rd,
  output logic [7:0]  host_rx_data,
  output logic        host_rx_done,
  output logic        host_rx_ovr,
  output logic        hs_timeout,
  uart_bus_if.master  uart
);

  logic tx_held, tx_start, tx_done, tx_abort, tx_busy;
  logic rx_start, rx_cap, rx_abort, rx_busy;

  // Byte stays held until the UART acks it or the handshake is abandoned.
  assign tx_start = tx_held && uart.tx_empty && !tx_busy;
  assign rx_start = !uart.rx_empty && !rx_busy;

  hs_initiator #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_tx (
    .clk(clk), .reset(reset), .start(tx_start), .ack(uart.ld_tx_ack),
    .req(uart.ld_tx_req), .done(tx_done), .abort(tx_abort), .busy(tx_busy)
  );

  hs_initiator #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_rx (
    .clk(clk), .reset(reset), .start(rx_start), .ack(uart.uld_rx_ack),
    .req(uart.uld_rx_req), .done(rx_cap), .abort(rx_abort), .busy(rx_busy)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uart.tx_data <= '0;
      tx_held      <= 1'b0;
      host_tx_rdy  <= 1'b1;
    end else if (host_tx_wr && host_tx_rdy) begin
      uart.tx_data <= host_tx_data;
      tx_held      <= 1'b1;
      host_tx_rdy  <= 1'b0;
    end else if (tx_done || tx_abort) begin
      tx_held <= 1'b0;
      if (tx_abort) host_tx_rdy <= 1'b1;
    end else if (!tx_held && !tx_busy && uart.tx_empty) begin
      host_tx_rdy <= 1'b1;
    end
  end

  // A read in the capture cycle consumed the old byte, so it is not an overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host_rx_data <= '0;
      host_rx_done <= 1'b0;
      host_rx_ovr  <= 1'b0;
    end else if (rx_cap) begin
      host_rx_data <= uart.rx_data;
      host_rx_done <= 1'b1;
      host_rx_ovr  <= host_rx_rd ? 1'b0 : (host_rx_ovr || host_rx_done);
    end else if (host_rx_rd) begin
      host_rx_done <= 1'b0;
      host_rx_ovr  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_timeout     <= 1'b0;
      uart.tx_enable <= 1'b0;
      uart.rx_enable <= 1'b0;
    end else begin
      uart.tx_enable <= 1'b1;
      uart.rx_enable <= 1'b1;
      if (tx_abort || rx_abort) hs_timeout <= 1'b1;
    end
  end

endmodule
